// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo PWM high-time decoder with 1 ms / 2 ms classification and loss detect
module servo_pwm_decoder #(
    parameter int TICKS_PER_US = 50,
    parameter int TIMEOUT_US   = 25000,
    parameter int MAX_HIGH_US  = 3000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [11:0] width_us,
    output logic [1:0]  position,
    output logic        sample_valid,
    output logic        signal_lost
);

    localparam int              PW         = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_US - 1);
    localparam logic [11:0]     MAX_C      = 12'(MAX_HIGH_US);
    localparam logic [14:0]     TIMEOUT_C  = 15'(TIMEOUT_US);

    typedef enum logic [1:0] {SEEK, ARMED, HIGH, LOW} state_t;

    state_t        state_q, state_d;
    logic          pwm_meta, pwm_s, pwm_d;
    logic          rise, fall, us_tick, take_rise, stuck, timeout;
    logic [PW-1:0] presc;
    logic [1:0]    sync_fill;
    logic [11:0]   high_cnt;
    logic [14:0]   gap_cnt;

    function automatic logic [1:0] classify(input logic [11:0] w);
        if (w >= 12'd800 && w <= 12'd1200)
            return 2'b01;
        else if (w >= 12'd1800 && w <= 12'd2200)
            return 2'b10;
        else
            return 2'b11;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pwm_meta  <= 1'b0;
            pwm_s     <= 1'b0;
            pwm_d     <= 1'b0;
            sync_fill <= 2'd0;
        end else begin
            pwm_meta <= pwm_in;
            pwm_s    <= pwm_meta;
            pwm_d    <= pwm_s;
            if (sync_fill != 2'd3)
                sync_fill <= sync_fill + 2'd1;
        end
    end

    assign rise      = pwm_s & ~pwm_d;
    assign fall      = ~pwm_s & pwm_d;
    assign us_tick   = (presc == PRESC_LAST);
    assign take_rise = rise && (state_q == ARMED || state_q == LOW);
    assign stuck     = (high_cnt >= MAX_C);
    assign timeout   = (gap_cnt >= TIMEOUT_C);

    always_ff @(posedge CLOCK_50) begin
        if (reset || rise || us_tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state_q <= SEEK;
        else
            state_q <= state_d;
    end

    // SEEK waits until the synchronizer holds real samples again, so a pulse
    // that was already high when reset released is not mistaken for a rise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEEK:       if (sync_fill == 2'd3 && !pwm_s) state_d = ARMED;
            ARMED, LOW: if (rise) state_d = HIGH;
            HIGH: begin
                if (fall)
                    state_d = LOW;
                else if (stuck)
                    state_d = SEEK;
            end
            default:    state_d = SEEK;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            high_cnt <= 12'd0;
            gap_cnt  <= 15'd0;
        end else begin
            if (take_rise)
                high_cnt <= 12'd0;
            else if (state_q == HIGH && us_tick && high_cnt != 12'hfff)
                high_cnt <= high_cnt + 12'd1;

            if (rise)
                gap_cnt <= 15'd0;
            else if (state_q != SEEK && us_tick && gap_cnt != 15'h7fff)
                gap_cnt <= gap_cnt + 15'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            width_us     <= 12'd0;
            position     <= 2'b00;
            sample_valid <= 1'b0;
            signal_lost  <= 1'b1;
        end else begin
            sample_valid <= 1'b0;
            if (take_rise) begin
                signal_lost <= 1'b0;
            end else if (timeout) begin
                signal_lost <= 1'b1;
                position    <= 2'b00;
            end

            if (state_q == HIGH && fall) begin
                width_us     <= high_cnt;
                position     <= classify(high_cnt);
                sample_valid <= 1'b1;
            end else if (state_q == HIGH && stuck) begin
                width_us     <= high_cnt;
                position     <= 2'b11;
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - directed self-checking bench for servo_pwm_decoder
module tb_servo_pwm_decoder;

    localparam int TPU = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [11:0] width_us;
    logic [1:0]  position;
    logic        sample_valid;
    logic        signal_lost;

    int n_checks = 0;
    int n_errors = 0;

    int          sv_count  = 0;
    int          sv_double = 0;
    logic        prev_sv   = 1'b0;
    logic [11:0] sv_width  = 12'd0;
    logic [1:0]  sv_pos    = 2'b00;

    servo_pwm_decoder #(
        .TICKS_PER_US(TPU),
        .TIMEOUT_US  (4000),
        .MAX_HIGH_US (3000)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .width_us    (width_us),
        .position    (position),
        .sample_valid(sample_valid),
        .signal_lost (signal_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_valid) begin
            sv_count = sv_count + 1;
            sv_width = width_us;
            sv_pos   = position;
            if (prev_sv)
                sv_double = sv_double + 1;
        end
        prev_sv = sample_valid;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_us(input int us);
        repeat (us * TPU) @(negedge clk);
    endtask

    task automatic measure(input string tag, input int hi, input int lo, input int pos_exp);
        int c0;
        c0 = sv_count;
        pwm_in = 1'b1;
        wait_us(hi);
        pwm_in = 1'b0;
        wait_us(5);
        check({tag, "_strobes"}, sv_count - c0, 1);
        check({tag, "_width_in_range"}, int'(sv_width >= 12'(hi - 1) && sv_width <= 12'(hi)), 1);
        check({tag, "_position"}, sv_pos, pos_exp);
        check({tag, "_lost"}, signal_lost, 0);
        wait_us(lo - 5);
    endtask

    initial begin
        int c0;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_width", width_us, 0);
        check("rst_position", position, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_lost", signal_lost, 1);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 3; i++)
            measure($sformatf("p1ms_%0d", i), 1000, 500, 1);
        measure("p2ms", 2000, 500, 2);
        measure("p1500", 1500, 500, 3);
        measure("p801", 801, 500, 1);
        measure("p2200", 2200, 500, 2);

        // stuck high: one strobe at 3000 us, none for the rest of the pulse
        c0 = sv_count;
        pwm_in = 1'b1;
        wait_us(3010);
        check("stuck_strobes", sv_count - c0, 1);
        check("stuck_width", sv_width, 3000);
        check("stuck_position", sv_pos, 3);
        wait_us(990);
        pwm_in = 1'b0;
        wait_us(500);
        check("stuck_no_more", sv_count - c0, 1);
        measure("after_stuck", 1000, 500, 1);

        // loss of signal 4000 us after the last rise
        pwm_in = 1'b1;
        wait_us(1000);
        pwm_in = 1'b0;
        wait_us(2990);
        check("pre_timeout_lost", signal_lost, 0);
        check("pre_timeout_position", position, 1);
        wait_us(20);
        check("timeout_lost", signal_lost, 1);
        check("timeout_position", position, 0);
        check("timeout_width_held", int'(width_us >= 12'd999 && width_us <= 12'd1000), 1);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        check("rise_clears_lost", signal_lost, 0);

        // reset released while the line is high mid-pulse
        wait_us(400);
        c0 = sv_count;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_us(600);
        pwm_in = 1'b0;
        wait_us(500);
        check("rst_high_no_strobe", sv_count - c0, 0);
        check("rst_high_lost", signal_lost, 1);
        measure("after_rst_high", 1000, 500, 1);

        // one-cycle reset 500 us into a 2000 us pulse
        c0 = sv_count;
        pwm_in = 1'b1;
        wait_us(500);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_width", width_us, 0);
        check("midrst_position", position, 0);
        check("midrst_sample_valid", sample_valid, 0);
        check("midrst_lost", signal_lost, 1);
        wait_us(1500);
        pwm_in = 1'b0;
        wait_us(500);
        check("midrst_no_strobe", sv_count - c0, 0);
        measure("after_midrst", 1000, 500, 1);

        check("no_double_strobe", sv_double, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 Parameter TICKS_PER_US, default 50: CLOCK_50 cycles per microsecond tick.
REQ-002 Parameter TIMEOUT_US, default 25000: microseconds without a rising edge before the signal is declared lost.
REQ-003 Parameter MAX_HIGH_US, default 3000: high time at which a pulse is declared stuck.
REQ-004 Port CLOCK_50, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port pwm_in, input, 1: asynchronous servo PWM line (nominal 20 ms period, 1 ms or 2 ms high).
REQ-007 Port width_us, output, 12: last measured high time in microseconds.
REQ-008 Port position, output, 2: 00 none, 01 = 1 ms pulse, 10 = 2 ms pulse, 11 = invalid width.
REQ-009 Port sample_valid, output, 1: one-cycle strobe when width_us and position update.
REQ-010 Port signal_lost, output, 1: level, high when no rising edge within TIMEOUT_US.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer (pwm_s), plus a delay flop (pwm_d); rise = pwm_s & ~pwm_d, fall = ~pwm_s & pwm_d.
REQ-012 A prescaler SHALL count 0..TICKS_PER_US-1 and emit us_tick at terminal count; it is cleared to 0 on every rise.
REQ-013 FSM states SHALL be SEEK, ARMED, HIGH, LOW; reset state SEEK.
REQ-014 SEEK -> ARMED when pwm_s = 0; a pulse already high at reset exit is never measured.
REQ-015 ARMED or LOW -> HIGH on rise; high_cnt (12-bit) and gap_cnt (15-bit) cleared to 0.
REQ-016 In HIGH, high_cnt SHALL increment on each us_tick, saturating at 4095.
REQ-017 HIGH -> LOW on fall: width_us <= high_cnt, position classified, sample_valid = 1 for exactly one cycle.
REQ-018 Classification: 800..1200 -> 01; 1800..2200 -> 10; any other value -> 11 (bounds inclusive).
REQ-019 HIGH with high_cnt reaching MAX_HIGH_US: width_us <= high_cnt, position <= 11, sample_valid pulse, next state SEEK.
REQ-020 gap_cnt SHALL increment on us_tick in all states except SEEK, saturating at 32767; cleared on rise.
REQ-021 gap_cnt reaching TIMEOUT_US: signal_lost <= 1, position <= 00, width_us held, state unchanged.
REQ-022 signal_lost SHALL clear on the cycle a rise is processed.
REQ-023 Output update latency SHALL be 3 CLOCK_50 edges after the pwm_in transition (2 sync + 1 register).
REQ-024 Measured width SHALL be within -1/+0 us of the true high time.
REQ-025 Rise and timeout in the same cycle: rise wins; signal_lost cleared, gap_cnt cleared.
REQ-026 All outputs SHALL be registered; sample_valid never asserts two consecutive cycles.

Reset
REQ-027 reset high at a clock edge SHALL force: width_us 0, position 00, sample_valid 0, signal_lost 1, state SEEK, sync/delay flops 0, prescaler, high_cnt and gap_cnt 0.
REQ-028 reset asserted mid-pulse SHALL abort the measurement with no sample_valid; the next measured pulse follows a low level.

Verification
REQ-029 Reset, then pwm_in 1000 us high / 19000 us low, 3 periods -> each fall: sample_valid one cycle, width_us 999..1000, position 01, signal_lost 0 after first rise.
REQ-030 Pulse 2000 us high -> width_us 1999..2000, position 10; then 1500 us high -> position 11, width_us 1499..1500.
REQ-031 pwm_in held high 5 ms after a valid rise -> at 3000 us sample_valid, position 11, width_us 3000; no further strobe until pwm_in low then rises again.
REQ-032 Stop pulses (pwm_in low) after a valid period -> signal_lost 1 and position 00 at 25000 us after last rise; next rise clears signal_lost.
REQ-033 Release reset with pwm_in high mid-pulse -> no sample_valid for that pulse; next full 1000 us pulse decodes as 01.
REQ-034 Assert reset for 1 cycle 500 us into a 2000 us pulse -> outputs at reset values next cycle, no strobe for that pulse.
